ps2_keyboard_matrix: RTL and testbench

Receives PS/2 keyboard frames and maintains the 8×8 active-low key matrix `KM[7:0]` that the LM80C keyboard scan logic reads through the PSG I/O ports. It sits between the host PS/2 pins and the `KM` input of the `lm80c` core. It decodes make/break/extended scan codes and sets or clears one matrix cell per key event.

---
 rtl/ps2_keyboard_matrix.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_ps2_keyboard_matrix.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_matrix.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver that maintains the LM80C 8x8 active-low key matrix.
// Latency: stop-bit edge in cycle N -> scan_valid/scan_code in N+1, KM in N+2.
// Backpressure: none; the PS/2 device cannot be stalled, every byte is consumed.
module ps2_keyboard_matrix #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic            sys_clock,
  input  logic            RESET,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  output logic [7:0][7:0] KM,
  output logic [7:0]      scan_code,
  output logic            scan_valid,
  output logic            frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } fstate_t;

  // Input synchronizers
  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_s;
  logic       dat_s;

  // Clock glitch filter
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fall;

  // Frame receiver
  fstate_t       fstate_q, fstate_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_vld;
  logic          byte_err;

  // Registered byte outputs
  logic [7:0] scan_code_q;
  logic       scan_valid_q;
  logic       frame_err_q;

  // Scan-code decoder
  logic            brk_q, brk_d;
  logic            ext_q, ext_d;
  logic [7:0][7:0] km_q, km_d;
  logic [6:0]      map;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // Two-stage synchronizers for both asynchronous PS/2 pins
  always_ff @(posedge sys_clock or posedge RESET) begin
    if (RESET) begin
      clk_sync_q <= 2'b00;
      dat_sync_q <= 2'b00;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive matching samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
        fall   = ~clk_s;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  // Filter state register
  always_ff @(posedge sys_clock or posedge RESET) begin
    if (RESET) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Frame FSM next state: start, 8 data bits LSB first, odd parity, stop
  always_comb begin
    fstate_d = fstate_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_ok_d = par_ok_q;
    tmo_d    = tmo_q;
    byte_vld = 1'b0;
    byte_err = 1'b0;

    if (fstate_q == F_IDLE || fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    case (fstate_q)
      F_IDLE: begin
        if (fall && !dat_s) begin
          fstate_d = F_DATA;
          bit_d    = 3'd0;
        end
      end
      F_DATA: begin
        if (fall) begin
          shift_d = {dat_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            fstate_d = F_PARITY;
          end
        end
      end
      F_PARITY: begin
        if (fall) begin
          par_ok_d = ^{shift_q, dat_s};
          fstate_d = F_STOP;
        end
      end
      F_STOP: begin
        if (fall) begin
          if (dat_s && par_ok_q) begin
            byte_vld = 1'b1;
          end else begin
            byte_err = 1'b1;
          end
          fstate_d = F_IDLE;
        end
      end
      default: fstate_d = F_IDLE;
    endcase

    // A device that stops clocking mid-frame abandons the frame
    if (fstate_q != F_IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
      fstate_d = F_IDLE;
      tmo_d    = '0;
      byte_vld = 1'b0;
      byte_err = 1'b1;
    end
  end

  // Frame FSM state register
  always_ff @(posedge sys_clock or posedge RESET) begin
    if (RESET) begin
      fstate_q <= F_IDLE;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      par_ok_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      fstate_q <= fstate_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_ok_q <= par_ok_d;
      tmo_q    <= tmo_d;
    end
  end

  // Register the received byte and the status pulses
  always_ff @(posedge sys_clock or posedge RESET) begin
    if (RESET) begin
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      scan_valid_q <= byte_vld;
      frame_err_q  <= byte_err;
      if (byte_vld) begin
        scan_code_q <= shift_q;
      end
    end
  end

  // Scan code to matrix cell: {hit, row[2:0], col[2:0]}
  function automatic logic [6:0] lookup(input logic ext, input logic [7:0] code);
    logic [6:0] r;
    r = 7'd0;
    case ({ext, code})
      {1'b0, 8'h66}: r = {1'b1, 3'd0, 3'd0};  // BACKSPACE
      {1'b0, 8'h76}: r = {1'b1, 3'd0, 3'd1};  // ESC
      {1'b0, 8'h05}: r = {1'b1, 3'd0, 3'd2};  // F1
      {1'b0, 8'h06}: r = {1'b1, 3'd0, 3'd3};  // F2
      {1'b0, 8'h04}: r = {1'b1, 3'd0, 3'd4};  // F3
      {1'b0, 8'h0C}: r = {1'b1, 3'd0, 3'd5};  // F4
      {1'b0, 8'h14}: r = {1'b1, 3'd0, 3'd6};  // CTRL
      {1'b0, 8'h5A}: r = {1'b1, 3'd0, 3'd7};  // RETURN
      {1'b0, 8'h1C}: r = {1'b1, 3'd1, 3'd0};  // A
      {1'b0, 8'h1B}: r = {1'b1, 3'd1, 3'd1};  // S
      {1'b0, 8'h23}: r = {1'b1, 3'd1, 3'd2};  // D
      {1'b0, 8'h2B}: r = {1'b1, 3'd1, 3'd3};  // F
      {1'b0, 8'h34}: r = {1'b1, 3'd1, 3'd4};  // G
      {1'b0, 8'h33}: r = {1'b1, 3'd1, 3'd5};  // H
      {1'b0, 8'h3B}: r = {1'b1, 3'd1, 3'd6};  // J
      {1'b0, 8'h42}: r = {1'b1, 3'd1, 3'd7};  // K
      {1'b0, 8'h15}: r = {1'b1, 3'd2, 3'd0};  // Q
      {1'b0, 8'h1D}: r = {1'b1, 3'd2, 3'd1};  // W
      {1'b0, 8'h24}: r = {1'b1, 3'd2, 3'd2};  // E
      {1'b0, 8'h2D}: r = {1'b1, 3'd2, 3'd3};  // R
      {1'b0, 8'h2C}: r = {1'b1, 3'd2, 3'd4};  // T
      {1'b0, 8'h35}: r = {1'b1, 3'd2, 3'd5};  // Y
      {1'b0, 8'h3C}: r = {1'b1, 3'd2, 3'd6};  // U
      {1'b0, 8'h43}: r = {1'b1, 3'd2, 3'd7};  // I
      {1'b0, 8'h1A}: r = {1'b1, 3'd3, 3'd0};  // Z
      {1'b0, 8'h22}: r = {1'b1, 3'd3, 3'd1};  // X
      {1'b0, 8'h21}: r = {1'b1, 3'd3, 3'd2};  // C
      {1'b0, 8'h2A}: r = {1'b1, 3'd3, 3'd3};  // V
      {1'b0, 8'h32}: r = {1'b1, 3'd3, 3'd4};  // B
      {1'b0, 8'h31}: r = {1'b1, 3'd3, 3'd5};  // N
      {1'b0, 8'h3A}: r = {1'b1, 3'd3, 3'd6};  // M
      {1'b0, 8'h44}: r = {1'b1, 3'd3, 3'd7};  // O
      {1'b0, 8'h16}: r = {1'b1, 3'd4, 3'd0};  // 1
      {1'b0, 8'h1E}: r = {1'b1, 3'd4, 3'd1};  // 2
      {1'b0, 8'h26}: r = {1'b1, 3'd4, 3'd2};  // 3
      {1'b0, 8'h25}: r = {1'b1, 3'd4, 3'd3};  // 4
      {1'b0, 8'h2E}: r = {1'b1, 3'd4, 3'd4};  // 5
      {1'b0, 8'h36}: r = {1'b1, 3'd4, 3'd5};  // 6
      {1'b0, 8'h3D}: r = {1'b1, 3'd4, 3'd6};  // 7
      {1'b0, 8'h3E}: r = {1'b1, 3'd4, 3'd7};  // 8
      {1'b0, 8'h46}: r = {1'b1, 3'd5, 3'd0};  // 9
      {1'b0, 8'h45}: r = {1'b1, 3'd5, 3'd1};  // 0
      {1'b0, 8'h4D}: r = {1'b1, 3'd5, 3'd2};  // P
      {1'b0, 8'h4B}: r = {1'b1, 3'd5, 3'd3};  // L
      {1'b0, 8'h29}: r = {1'b1, 3'd5, 3'd4};  // SPACE
      {1'b0, 8'h41}: r = {1'b1, 3'd5, 3'd5};  // ,
      {1'b0, 8'h49}: r = {1'b1, 3'd5, 3'd6};  // .
      {1'b0, 8'h4A}: r = {1'b1, 3'd5, 3'd7};  // /
      {1'b0, 8'h4C}: r = {1'b1, 3'd6, 3'd4};  // ;
      {1'b0, 8'h52}: r = {1'b1, 3'd6, 3'd5};  // '
      {1'b0, 8'h54}: r = {1'b1, 3'd6, 3'd6};  // [
      {1'b0, 8'h5B}: r = {1'b1, 3'd6, 3'd7};  // ]
      {1'b0, 8'h4E}: r = {1'b1, 3'd7, 3'd0};  // -
      {1'b0, 8'h55}: r = {1'b1, 3'd7, 3'd1};  // =
      {1'b0, 8'h5D}: r = {1'b1, 3'd7, 3'd2};  // backslash
      {1'b0, 8'h0E}: r = {1'b1, 3'd7, 3'd3};  // backtick
      {1'b0, 8'h0D}: r = {1'b1, 3'd7, 3'd4};  // TAB
      {1'b0, 8'h58}: r = {1'b1, 3'd7, 3'd5};  // CAPS LOCK
      {1'b0, 8'h12}: r = {1'b1, 3'd7, 3'd6};  // left SHIFT
      {1'b0, 8'h59}: r = {1'b1, 3'd7, 3'd6};  // right SHIFT, same cell
      {1'b0, 8'h11}: r = {1'b1, 3'd7, 3'd7};  // ALT
      {1'b1, 8'h72}: r = {1'b1, 3'd6, 3'd0};  // cursor down
      {1'b1, 8'h75}: r = {1'b1, 3'd6, 3'd1};  // cursor up
      {1'b1, 8'h6B}: r = {1'b1, 3'd6, 3'd2};  // cursor left
      {1'b1, 8'h74}: r = {1'b1, 3'd6, 3'd3};  // cursor right
      {1'b1, 8'h71}: r = {1'b1, 3'd0, 3'd0};  // DELETE acts as backspace
      {1'b1, 8'h5A}: r = {1'b1, 3'd0, 3'd7};  // keypad ENTER
      {1'b1, 8'h14}: r = {1'b1, 3'd0, 3'd6};  // right CTRL
      {1'b1, 8'h11}: r = {1'b1, 3'd7, 3'd7};  // right ALT
      default:       r = 7'd0;                // includes E0 12 (fake shift)
    endcase
    return r;
  endfunction

  assign map = lookup(ext_q, scan_code_q);

  // Decode prefixes and apply one make/break event to the matrix per byte
  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    km_d  = km_q;
    if (frame_err_q) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (scan_valid_q) begin
      case (scan_code_q)
        8'hF0: brk_d = 1'b1;
        8'hE0: ext_d = 1'b1;
        8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00: begin
          // protocol chatter: leave flags and matrix alone
        end
        default: begin
          if (map[6]) begin
            km_d[map[5:3]][map[2:0]] = brk_q;
          end
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
      endcase
    end
  end

  // Decoder flags and matrix registers
  always_ff @(posedge sys_clock or posedge RESET) begin
    if (RESET) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      km_q  <= '1;
    end else begin
      brk_q <= brk_d;
      ext_q <= ext_d;
      km_q  <= km_d;
    end
  end

  assign KM         = km_q;
  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
`timescale 1ns/1ps
// Directed bench for ps2_keyboard_matrix: framed bytes in, scoreboard on scan_code,
// matrix and pulse counts checked after each key sequence.
// Bytes are driven at a PS/2 half-period well above the filter minimum.
module tb_ps2_keyboard_matrix;

  localparam int FL = 8;
  localparam int TO = 1000;
  localparam int HP = 20;
  localparam logic [63:0] ALL_UP = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            sys_clock = 1'b0;
  logic            RESET     = 1'b1;
  logic            ps2_clk   = 1'b1;
  logic            ps2_data  = 1'b1;
  logic [7:0][7:0] KM;
  logic [7:0]      scan_code;
  logic            scan_valid;
  logic            frame_err;

  int n_chk   = 0;
  int n_fail  = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int v0;
  int e0;

  logic [7:0]      exp_q[$];
  logic [7:0][7:0] km_at_valid;
  logic [7:0][7:0] km_after;
  logic [7:0][7:0] km_exp;

  always #5 sys_clock = ~sys_clock;

  ps2_keyboard_matrix #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .sys_clock  (sys_clock),
    .RESET      (RESET),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .KM         (KM),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts pulses, pops the scoreboard, captures KM around each byte
  initial begin
    logic [63:0] want;
    forever begin
      @(negedge sys_clock);
      if (frame_err === 1'b1) err_cnt++;
      if (scan_valid === 1'b1) begin
        vld_cnt++;
        km_at_valid = KM;
        if (exp_q.size() > 0) want = {56'd0, exp_q.pop_front()};
        else want = 64'h1FF;
        check("scan_code", {56'd0, scan_code}, want);
        @(negedge sys_clock);
        km_after = KM;
        if (frame_err === 1'b1) err_cnt++;
      end
    end
  end

  task automatic put_bit(input logic b);
    ps2_data = b;
    repeat (HP) @(posedge sys_clock);
    #1 ps2_clk = 1'b0;
    repeat (HP) @(posedge sys_clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    if (!bad_par && !bad_stop) exp_q.push_back(b);
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    put_bit((~^b) ^ bad_par);
    put_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (2 * HP) @(posedge sys_clock);
  endtask

  initial begin
    km_exp = ALL_UP;

    // Reset values
    repeat (3) @(negedge sys_clock);
    check("rst_km", KM, ALL_UP);
    check("rst_scan_code", {56'd0, scan_code}, 64'd0);
    check("rst_scan_valid", {63'd0, scan_valid}, 64'd0);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    @(posedge sys_clock);
    #1 RESET = 1'b0;
    repeat (30) @(posedge sys_clock);

    // Press A: matrix unchanged when scan_valid shows, updated one cycle later
    v0 = vld_cnt;
    e0 = err_cnt;
    send(8'h1C);
    km_exp[1] = 8'hFE;
    check("press_km_at_valid", km_at_valid, ALL_UP);
    check("press_km_next", km_after, km_exp);
    check("press_km", KM, km_exp);

    // Release A
    send(8'hF0);
    send(8'h1C);
    km_exp[1] = 8'hFF;
    check("release_km", KM, km_exp);
    check("release_valid_count", 64'(vld_cnt - v0), 64'd3);
    check("release_err_count", 64'(err_cnt - e0), 64'd0);

    // Extended cursor up press and release
    send(8'hE0);
    send(8'h75);
    km_exp[6] = 8'hFD;
    check("ext_up_press", KM, km_exp);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    km_exp[6] = 8'hFF;
    check("ext_up_release", KM, km_exp);

    // E0 12 is unmapped and must not leave ext set for the next byte
    send(8'hE0);
    send(8'h12);
    check("ext_fake_shift", KM, km_exp);
    send(8'h1C);
    km_exp[1] = 8'hFE;
    check("after_fake_shift_press", KM, km_exp);
    send(8'hF0);
    send(8'h1C);
    km_exp[1] = 8'hFF;
    check("after_fake_shift_release", KM, km_exp);

    // Shared SHIFT cell: left press, right release
    send(8'h12);
    km_exp[7] = 8'hBF;
    check("shift_press", KM, km_exp);
    send(8'hF0);
    send(8'h59);
    km_exp[7] = 8'hFF;
    check("shift_release", KM, km_exp);

    // Parity error
    v0 = vld_cnt;
    e0 = err_cnt;
    send(8'h1C, 1'b1, 1'b0);
    check("parity_err_count", 64'(err_cnt - e0), 64'd1);
    check("parity_valid_count", 64'(vld_cnt - v0), 64'd0);
    check("parity_km", KM, km_exp);

    // Bad stop after F0 clears the break flag
    send(8'hF0);
    e0 = err_cnt;
    send(8'h1C, 1'b0, 1'b1);
    check("stop_err_count", 64'(err_cnt - e0), 64'd1);
    send(8'h1C);
    km_exp[1] = 8'hFE;
    check("stop_then_press", KM, km_exp);
    send(8'hF0);
    send(8'h1C);
    km_exp[1] = 8'hFF;
    check("stop_then_release", KM, km_exp);

    // Timeout mid-frame
    e0 = err_cnt;
    v0 = vld_cnt;
    put_bit(1'b0);
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TO + 100) @(posedge sys_clock);
    check("timeout_err_count", 64'(err_cnt - e0), 64'd1);
    check("timeout_valid_count", 64'(vld_cnt - v0), 64'd0);
    send(8'h5A);
    km_exp[0] = 8'h7F;
    check("timeout_then_return", KM, km_exp);

    // Reset mid-frame
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    @(negedge sys_clock);
    RESET = 1'b1;
    #1;
    check("midrst_km", KM, ALL_UP);
    check("midrst_scan_code", {56'd0, scan_code}, 64'd0);
    check("midrst_scan_valid", {63'd0, scan_valid}, 64'd0);
    check("midrst_frame_err", {63'd0, frame_err}, 64'd0);
    @(posedge sys_clock);
    #1 RESET = 1'b0;
    ps2_data = 1'b1;
    e0 = err_cnt;
    v0 = vld_cnt;
    repeat (TO + 100) @(posedge sys_clock);
    check("midrst_no_err", 64'(err_cnt - e0), 64'd0);
    check("midrst_no_valid", 64'(vld_cnt - v0), 64'd0);
    km_exp = ALL_UP;
    send(8'h1C);
    km_exp[1] = 8'hFE;
    check("midrst_then_press", KM, km_exp);
    check("midrst_then_code", {56'd0, scan_code}, 64'h1C);

    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
